// File: rtl/lut_cfg_pkg.sv
// Shared types and constants for the LUT6_2 configuration chain.
// Imported by the controller and the readback packer.
package lut_cfg_pkg;

    localparam int LUT6_2_CFG_BITS = 64;
    localparam int LUT5_CFG_BITS   = 32;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT,
        DRAIN
    } cfg_state_e;

    function automatic int chain_words(input int chain_len, input int word_w);
        return chain_len / word_w;
    endfunction

endpackage

// File: rtl/lut_cfg_rb_pack.sv
// Serial-in, word-out packer for bits ejected from the chain tail.
// A full collector with a busy output register raises stall.
module lut_cfg_rb_pack
    import lut_cfg_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              bit_en,
    input  logic              bit_in,
    input  logic              rb_ready,
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data,
    output logic              stall,
    output logic              idle
);

    localparam int BW = $clog2(WORD_W);
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);

    logic [WORD_W-1:0] col_q;
    logic [WORD_W-1:0] col_d;
    logic [WORD_W-1:0] col_word;
    logic [WORD_W-1:0] rbd_d;
    logic [BW-1:0]     cnt_q;
    logic [BW-1:0]     cnt_d;
    logic              full_q;
    logic              full_d;
    logic              rbv_d;
    logic              out_free;
    logic              last_bit;

    assign out_free = !rb_valid || rb_ready;
    assign last_bit = bit_en && (cnt_q == BIT_LAST);
    assign col_word = {col_q[WORD_W-2:0], bit_in};
    assign stall    = full_d;
    assign idle     = !full_q && (cnt_q == '0);

    // Collect bits, hand complete words to the output register.
    always_comb begin
        col_d  = col_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        rbv_d  = rb_valid;
        rbd_d  = rb_data;
        if (rb_valid && rb_ready) begin
            rbv_d = 1'b0;
        end
        if (clr) begin
            col_d  = '0;
            cnt_d  = '0;
            full_d = 1'b0;
            rbv_d  = 1'b0;
            rbd_d  = '0;
        end else if (full_q) begin
            if (out_free) begin
                rbd_d  = col_q;
                rbv_d  = 1'b1;
                full_d = 1'b0;
            end
        end else if (bit_en) begin
            col_d = col_word;
            cnt_d = last_bit ? '0 : cnt_q + 1'b1;
            if (last_bit) begin
                if (out_free) begin
                    rbd_d = col_word;
                    rbv_d = 1'b1;
                end else begin
                    full_d = 1'b1;
                end
            end
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q    <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            rb_valid <= 1'b0;
            rb_data  <= '0;
        end else begin
            col_q    <= col_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            rb_valid <= rbv_d;
            rb_data  <= rbd_d;
        end
    end

endmodule

// File: rtl/lut_chain_cfg_ctrl.sv
// Serialises host words onto a cascaded LUT6_2 config chain and
// repacks the ejected bits into readback words.
module lut_chain_cfg_ctrl
    import lut_cfg_pkg::*;
#(
    parameter int N_LUTS = 4,
    parameter int WORD_W = 32
) (
    input  logic              config_clk,
    input  logic              config_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              cfg_valid,
    input  logic [WORD_W-1:0] cfg_data,
    output logic              cfg_ready,
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data,
    input  logic              rb_ready,
    output logic              config_in,
    output logic              config_en,
    input  logic              config_out,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int CHAIN_LEN = N_LUTS * LUT6_2_CFG_BITS;
    localparam int N_WORDS   = chain_words(CHAIN_LEN, WORD_W);
    localparam int BW        = $clog2(WORD_W);
    localparam int WW        = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(N_WORDS - 1);

    cfg_state_e        state_q;
    cfg_state_e        state_d;
    logic [WORD_W-1:0] sr_q;
    logic [WORD_W-1:0] sr_d;
    logic [BW-1:0]     bcnt_q;
    logic [BW-1:0]     bcnt_d;
    logic [WW-1:0]     wcnt_q;
    logic [WW-1:0]     wcnt_d;
    logic              cen_q;
    logic              cen_d;
    logic              cin_q;
    logic              cin_d;
    logic              done_q;
    logic              done_d;
    logic              abt_q;
    logic              abt_d;
    logic              pk_stall;
    logic              pk_idle;

    assign config_en = cen_q;
    assign config_in = cin_q;
    assign done      = done_q;
    assign aborted   = abt_q;
    assign busy      = (state_q != IDLE);

    // Capture runs on the same edge the chain shifts.
    lut_cfg_rb_pack #(
        .WORD_W(WORD_W)
    ) u_pack (
        .clk     (config_clk),
        .rst_n   (config_rst_n),
        .clr     (abort),
        .bit_en  (cen_q),
        .bit_in  (config_out),
        .rb_ready(rb_ready),
        .rb_valid(rb_valid),
        .rb_data (rb_data),
        .stall   (pk_stall),
        .idle    (pk_idle)
    );

    // Next state, shift decision and word reload (zero-bubble).
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bcnt_d    = bcnt_q;
        wcnt_d    = wcnt_q;
        cen_d     = 1'b0;
        cin_d     = cin_q;
        done_d    = 1'b0;
        abt_d     = 1'b0;
        cfg_ready = 1'b0;
        if (abort) begin
            state_d = IDLE;
            bcnt_d  = '0;
            wcnt_d  = '0;
            cin_d   = 1'b0;
            abt_d   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = FETCH;
                        bcnt_d  = '0;
                        wcnt_d  = '0;
                    end
                end
                FETCH: begin
                    cfg_ready = 1'b1;
                    if (cfg_valid) begin
                        sr_d    = cfg_data;
                        bcnt_d  = '0;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (!pk_stall) begin
                        cen_d = 1'b1;
                        cin_d = sr_q[WORD_W-1];
                        sr_d  = {sr_q[WORD_W-2:0], 1'b0};
                        if (bcnt_q == BIT_LAST) begin
                            bcnt_d = '0;
                            if (wcnt_q == WORD_LAST) begin
                                state_d = DRAIN;
                            end else begin
                                cfg_ready = 1'b1;
                                wcnt_d    = wcnt_q + 1'b1;
                                if (cfg_valid) begin
                                    sr_d = cfg_data;
                                end else begin
                                    state_d = FETCH;
                                end
                            end
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!cen_q && pk_idle && rb_valid && rb_ready) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Controller registers; async reset drops config_en at once.
    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            cen_q   <= 1'b0;
            cin_q   <= 1'b0;
            done_q  <= 1'b0;
            abt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            cen_q   <= cen_d;
            cin_q   <= cin_d;
            done_q  <= done_d;
            abt_q   <= abt_d;
        end
    end

endmodule
